// File: rtl/dm_wb_stage_ctl_pkg.sv
// Shared types and defaults for the DM->WB pipeline register and its load extractor.
package dm_wb_stage_ctl_pkg;

  localparam int DM_DSIZE = 16;
  localparam int DM_ASIZE = 4;

  // Load-size encodings seen on ld_size_in. The value 2'b11 behaves like a word load.
  typedef enum logic [1:0] {
    LD_WORD     = 2'b00,
    LD_BU       = 2'b01,
    LD_BS       = 2'b10,
    LD_WORD_ALT = 2'b11
  } ld_size_e;

  // Control fields that travel with each entry through the stage.
  typedef struct packed {
    logic     valid;
    logic     wen;
    logic     mem_to_reg;
    ld_size_e ld_size;
  } ctl_t;

  // Width of the byte-lane index for a datapath of dsize bits.
  function automatic int lane_width(input int dsize);
    return $clog2(dsize / 8);
  endfunction

endpackage

// File: rtl/dm_wb_stage_ctl_load_extract.sv
// Combinational sub-word load extraction: selects one byte lane, then zero- or sign-extends it.
module dm_wb_stage_ctl_load_extract
  import dm_wb_stage_ctl_pkg::*;
#(
  parameter int DSIZE  = DM_DSIZE,
  parameter int LANE_W = lane_width(DSIZE)
) (
  input  logic [DSIZE-1:0]  dm_in,
  input  logic [LANE_W-1:0] lane,
  input  ld_size_e          ld_size,
  output logic [DSIZE-1:0]  data_out
);

  localparam int NBYTES = DSIZE / 8;

  logic [7:0] sel_byte;

  always_comb begin
    // NOTE: every output gets a default before the loop and case, so no path can infer a latch.
    sel_byte = '0;
    data_out = dm_in;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane == LANE_W'(i)) sel_byte = dm_in[8*i +: 8];
    end
    case (ld_size)
      LD_BU:   data_out = {{(DSIZE-8){1'b0}}, sel_byte};
      LD_BS:   data_out = {{(DSIZE-8){sel_byte[7]}}, sel_byte};
      default: data_out = dm_in;
    endcase
  end

endmodule

// File: rtl/dm_wb_stage_ctl.sv
// DM->WB pipeline register with stall/flush control, valid tracking, r0 write suppression,
// sub-word load extraction, the writeback mux and a saturating retired-instruction counter.
module dm_wb_stage_ctl
  import dm_wb_stage_ctl_pkg::*;
#(
  parameter int DSIZE    = DM_DSIZE,
  parameter int ASIZE    = DM_ASIZE,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             wen_in,
  input  logic             MemtoReg_in,
  input  logic [1:0]       ld_size_in,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [DSIZE-1:0] dm_in,
  output logic             valid_out,
  output logic             wen_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic [DSIZE-1:0] aluout_out,
  output logic [DSIZE-1:0] dm_out,
  output logic [DSIZE-1:0] wb_data,
  output logic [CNT_W-1:0] retired
);

  localparam int              LANE_W  = lane_width(DSIZE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctl_t             ctl_q, ctl_d;
  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic [DSIZE-1:0] aluout_q, aluout_d;
  logic [DSIZE-1:0] dm_q, dm_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             dst_is_zero;
  logic             retire_now;
  logic [DSIZE-1:0] ext_data;

  assign dst_is_zero = (ZERO_REG != 0) && (waddr_in == '0);

  // A flush still lets the held entry leave, so it counts even when stall is also high.
  assign retire_now = ctl_q.valid & (flush | ~stall);

  always_comb begin
    ctl_d    = ctl_q;
    waddr_d  = waddr_q;
    aluout_d = aluout_q;
    dm_d     = dm_q;
    if (flush || !stall) begin
      waddr_d            = waddr_in;
      aluout_d           = aluout_in;
      dm_d               = dm_in;
      ctl_d.mem_to_reg   = MemtoReg_in;
      ctl_d.ld_size      = ld_size_e'(ld_size_in);
      ctl_d.valid        = valid_in & ~flush;
      ctl_d.wen          = wen_in & valid_in & ~dst_is_zero & ~flush;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (retire_now && (retired_q != CNT_MAX)) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples the pre-edge _d values together.
    if (rst) begin
      ctl_q     <= '0;
      waddr_q   <= '0;
      aluout_q  <= '0;
      dm_q      <= '0;
      retired_q <= '0;
    end else begin
      ctl_q     <= ctl_d;
      waddr_q   <= waddr_d;
      aluout_q  <= aluout_d;
      dm_q      <= dm_d;
      retired_q <= retired_d;
    end
  end

  dm_wb_stage_ctl_load_extract #(
    .DSIZE  (DSIZE),
    .LANE_W (LANE_W)
  ) u_load_extract (
    .dm_in    (dm_q),
    .lane     (aluout_q[LANE_W-1:0]),
    .ld_size  (ctl_q.ld_size),
    .data_out (ext_data)
  );

  assign valid_out  = ctl_q.valid;
  assign wen_out    = ctl_q.wen;
  assign waddr_out  = waddr_q;
  assign aluout_out = aluout_q;
  assign dm_out     = dm_q;
  assign wb_data    = ctl_q.mem_to_reg ? ext_data : aluout_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_dm_wb_stage_ctl.sv
// Self-checking bench for dm_wb_stage_ctl: directed vector table, hand-written stall/flush
// sequences and randomized traffic against a behavioural model (16-bit and 3-bit counters).
module tb_dm_wb_stage_ctl;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, wen_in, mtr_in;
  logic [1:0]  ld_in;
  logic [15:0] alu_in, dm_in;
  logic [3:0]  waddr_in;

  logic        valid_out, wen_out, valid_out3, wen_out3;
  logic [3:0]  waddr_out, waddr_out3;
  logic [15:0] aluout_out, dm_out, wb_data, aluout_out3, dm_out3, wb_data3;
  logic [15:0] retired;
  logic [2:0]  retired3;

  always #5 clk = ~clk;

  dm_wb_stage_ctl #(.DSIZE(16), .ASIZE(4), .ZERO_REG(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .wen_in(wen_in), .MemtoReg_in(mtr_in), .ld_size_in(ld_in), .aluout_in(alu_in),
    .waddr_in(waddr_in), .dm_in(dm_in), .valid_out(valid_out), .wen_out(wen_out),
    .waddr_out(waddr_out), .aluout_out(aluout_out), .dm_out(dm_out), .wb_data(wb_data),
    .retired(retired)
  );

  dm_wb_stage_ctl #(.DSIZE(16), .ASIZE(4), .ZERO_REG(1), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .wen_in(wen_in), .MemtoReg_in(mtr_in), .ld_size_in(ld_in), .aluout_in(alu_in),
    .waddr_in(waddr_in), .dm_in(dm_in), .valid_out(valid_out3), .wen_out(wen_out3),
    .waddr_out(waddr_out3), .aluout_out(aluout_out3), .dm_out(dm_out3), .wb_data(wb_data3),
    .retired(retired3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: the entry currently held plus plain integer retire counts.
  bit          m_valid, m_wen, m_mtr, m_known;
  int          m_ld, m_alu, m_dm, m_waddr;
  int          m_cnt, m_cnt3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_wb();
    int lane, b;
    lane = m_alu % 2;
    b    = (m_dm / (1 << (8 * lane))) % 256;
    if (!m_mtr) return m_alu;
    if (m_ld == 1) return b;
    if (m_ld == 2) return (b >= 128) ? (b + 65536 - 256) : b;
    return m_dm;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_valid = 0; m_wen = 0; m_mtr = 0; m_ld = 0; m_alu = 0; m_dm = 0; m_waddr = 0;
      m_cnt = 0; m_cnt3 = 0; m_known = 1;
    end else begin
      if (m_valid && (flush || !stall)) begin
        m_cnt  = sat(m_cnt + 1, 65535);
        m_cnt3 = sat(m_cnt3 + 1, 7);
      end
      if (flush) begin
        m_valid = 0; m_wen = 0; m_known = 0;
      end else if (!stall) begin
        m_valid = valid_in;
        m_wen   = wen_in && valid_in && (waddr_in != 0);
        m_mtr   = mtr_in;
        m_ld    = int'(ld_in);
        m_alu   = int'(alu_in);
        m_dm    = int'(dm_in);
        m_waddr = int'(waddr_in);
        m_known = 1;
      end
    end
  endtask

  // Inputs are driven just after a falling edge; outputs are compared at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},    {31'd0, valid_out}, {31'd0, m_valid});
    check({tag, ".wen"},      {31'd0, wen_out},   {31'd0, m_wen});
    check({tag, ".retired"},  {16'd0, retired},   m_cnt);
    check({tag, ".retired3"}, {29'd0, retired3},  m_cnt3);
    if (m_known) begin
      check({tag, ".waddr"},  {28'd0, waddr_out},  m_waddr);
      check({tag, ".aluout"}, {16'd0, aluout_out}, m_alu);
      check({tag, ".dm"},     {16'd0, dm_out},     m_dm);
      check({tag, ".wb"},     {16'd0, wb_data},    model_wb());
    end
  endtask

  task automatic drive(input bit v, input bit w, input bit m, input logic [1:0] ld,
                       input logic [15:0] alu, input logic [15:0] dm, input logic [3:0] wa);
    valid_in = v; wen_in = w; mtr_in = m; ld_in = ld; alu_in = alu; dm_in = dm; waddr_in = wa;
  endtask

  typedef struct {
    bit          v, w, m;
    logic [1:0]  ld;
    logic [15:0] alu, dm;
    logic [3:0]  wa;
    bit          exp_valid, exp_wen;
    logic [15:0] exp_wb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    vecs[0] = '{1, 1, 1, 2'b10, 16'h0001, 16'h80FF, 4'd3, 1, 1, 16'hFF80};
    vecs[1] = '{1, 1, 1, 2'b01, 16'h0001, 16'h80FF, 4'd3, 1, 1, 16'h0080};
    vecs[2] = '{1, 1, 1, 2'b10, 16'h0000, 16'h80FF, 4'd3, 1, 1, 16'hFFFF};
    vecs[3] = '{1, 1, 0, 2'b00, 16'h1234, 16'hDEAD, 4'd5, 1, 1, 16'h1234};
    vecs[4] = '{1, 1, 0, 2'b00, 16'h1234, 16'hDEAD, 4'd0, 1, 0, 16'h1234};
    vecs[5] = '{1, 1, 1, 2'b00, 16'h0000, 16'hABCD, 4'd7, 1, 1, 16'hABCD};
    vecs[6] = '{1, 1, 1, 2'b11, 16'h0001, 16'hABCD, 4'd7, 1, 1, 16'hABCD};
    vecs[7] = '{0, 1, 0, 2'b00, 16'h5555, 16'h0000, 4'd2, 0, 0, 16'h5555};
    vecs[8] = '{1, 0, 1, 2'b01, 16'h0000, 16'h80FF, 4'd9, 1, 0, 16'h00FF};

    // Reset with arbitrary inputs for two cycles.
    rst = 1; stall = 1; flush = 0;
    drive(1, 1, 1, 2'b10, 16'hBEEF, 16'hCAFE, 4'd6);
    cycle();
    stall = 0; flush = 1;
    cycle();
    check("rst.valid",    {31'd0, valid_out}, 0);
    check("rst.wen",      {31'd0, wen_out},   0);
    check("rst.waddr",    {28'd0, waddr_out}, 0);
    check("rst.aluout",   {16'd0, aluout_out}, 0);
    check("rst.dm",       {16'd0, dm_out},    0);
    check("rst.wb",       {16'd0, wb_data},   0);
    check("rst.retired",  {16'd0, retired},   0);
    check("rst.retired3", {29'd0, retired3},  0);
    rst = 0; flush = 0;

    // Directed single-load vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].m, vecs[i].ld, vecs[i].alu, vecs[i].dm, vecs[i].wa);
      cycle();
      check($sformatf("vec%0d.valid", i), {31'd0, valid_out}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d.wen", i),   {31'd0, wen_out},   {31'd0, vecs[i].exp_wen});
      check($sformatf("vec%0d.wb", i),    {16'd0, wb_data},   {16'd0, vecs[i].exp_wb});
      check_all($sformatf("vec%0d", i));
    end

    // Stall: entry A held for three cycles, counted once at release.
    drive(1, 1, 0, 2'b00, 16'h1111, 16'h0000, 4'd1);
    cycle();
    base  = m_cnt;
    stall = 1;
    drive(1, 1, 0, 2'b00, 16'h2222, 16'h0000, 4'd2);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("stall%0d.aluout", k), {16'd0, aluout_out}, 32'h1111);
      check($sformatf("stall%0d.wb", k),     {16'd0, wb_data},    32'h1111);
      check($sformatf("stall%0d.retired", k), {16'd0, retired},   base);
    end
    stall = 0;
    cycle();
    check("release.aluout",  {16'd0, aluout_out}, 32'h2222);
    check("release.retired", {16'd0, retired},    base + 1);

    // Flush together with stall: bubble wins and the held entry still retires.
    stall = 1; flush = 1;
    cycle();
    check("flushstall.valid",   {31'd0, valid_out}, 0);
    check("flushstall.wen",     {31'd0, wen_out},   0);
    check("flushstall.retired", {16'd0, retired},   base + 2);
    stall = 0; flush = 0;

    // Ten back-to-back entries then two flushes; the 3-bit counter saturates.
    rst = 1;
    cycle();
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 2'b00, 16'(k + 16'h0100), 16'h0000, 4'(k + 1));
      cycle();
      check_all($sformatf("b2b%0d", k));
    end
    flush = 1;
    cycle();
    cycle();
    flush = 0;
    check("b2b.retired",  {16'd0, retired},  10);
    check("b2b.retired3", {29'd0, retired3}, 7);
    check("b2b.valid",    {31'd0, valid_out}, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
      cycle();
      check_all($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
